// File: rtl/alu_result_fifo_if.sv
// -----------------------------------------------------------------------------
// alu_result_fifo_if
//   Handshake bundle between an ALU output register (producer), the result
//   FIFO, and the consumer that drains it.
//   Producer side : in_valid, r_in, c_in, z_in, n_in, v_in
//   Consumer side : out_ready (from consumer), out_valid, r_out, c_out, z_out,
//                   n_out, v_out (to consumer)
//   Modports:
//     master - environment view (drives push data and out_ready)
//     slave  - FIFO view (drives head entry and out_valid)
// -----------------------------------------------------------------------------
interface alu_result_fifo_if #(
  parameter int N = 2
);
  logic         in_valid;
  logic [N-1:0] r_in;
  logic         c_in;
  logic         z_in;
  logic         n_in;
  logic         v_in;

  logic         out_ready;
  logic         out_valid;
  logic [N-1:0] r_out;
  logic         c_out;
  logic         z_out;
  logic         n_out;
  logic         v_out;

  modport master (
    output in_valid, r_in, c_in, z_in, n_in, v_in, out_ready,
    input  out_valid, r_out, c_out, z_out, n_out, v_out
  );

  modport slave (
    input  in_valid, r_in, c_in, z_in, n_in, v_in, out_ready,
    output out_valid, r_out, c_out, z_out, n_out, v_out
  );
endinterface

// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//   Captures ALU result r and flags {c,z,n,v} into a DEPTH-entry FIFO so the
//   ALU issue rate is decoupled from the consumer rate. Drops on a full FIFO
//   are reported through a sticky overflow bit.
//
// Parameters
//   N      result width (must match the ALU)
//   DEPTH  number of entries, power of 2, >= 2
//
// Ports
//   clk, rst      single rising-edge clock, synchronous active-high reset
//   bus (slave)   push side (in_valid, r_in, flags) and pop side
//                 (out_ready, out_valid, r_out, flags)
//   clr_ovf       clears overflow next edge (a new drop wins)
//   full, empty   occupancy status decoded from the occupancy state
//   count         occupancy 0..DEPTH
//   overflow      sticky: a push was dropped
//   sticky_flags  OR of {c,z,n,v} over accepted pushes  (STICKY_FLAGS_EN)
//   clr_sticky    clears sticky_flags next edge          (STICKY_FLAGS_EN)
//
// Build option
//   STICKY_FLAGS_EN - when defined, adds sticky_flags/clr_sticky. FIFO
//   behaviour is identical either way.
// -----------------------------------------------------------------------------
module alu_result_fifo #(
  parameter int N     = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_result_fifo_if.slave       bus,
  input  logic                   clr_ovf,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
`ifdef STICKY_FLAGS_EN
  ,
  output logic [3:0]             sticky_flags,
  input  logic                   clr_sticky
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = N + 4;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } occ_state_t;

  occ_state_t       state_reg, state_next;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] entry_in;
  logic [ENT_W-1:0] entry_head;

  logic push;
  logic pop;
  logic drop;

  // Status decoded from the registered occupancy state.
  assign empty         = (state_reg == ST_EMPTY);
  assign full          = (state_reg == ST_FULL);
  assign bus.out_valid = !empty;
  assign count         = count_reg;
  assign overflow      = overflow_reg;

  assign pop  = bus.out_valid & bus.out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = bus.in_valid & (!full | pop);
  assign drop = bus.in_valid & full & !pop;

  assign entry_in   = {bus.r_in, bus.c_in, bus.z_in, bus.n_in, bus.v_in};
  assign entry_head = mem[rd_ptr_reg];

  // Head is masked when empty so the consumer never sees stale storage.
  assign bus.r_out = bus.out_valid ? entry_head[ENT_W-1:4] : '0;
  assign bus.c_out = bus.out_valid & entry_head[3];
  assign bus.z_out = bus.out_valid & entry_head[2];
  assign bus.n_out = bus.out_valid & entry_head[1];
  assign bus.v_out = bus.out_valid & entry_head[0];

  assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

  // Storage: not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr_reg] <= entry_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_EMPTY;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      // Power-of-2 depth: pointers wrap without explicit compare.
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clr_ovf) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // Occupancy changes by at most one per cycle, so EMPTY and FULL are only
  // ever connected through PARTIAL, even for DEPTH=2.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (push) state_next = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (count_next == CNT_W'(DEPTH)) begin
          state_next = ST_FULL;
        end else if (count_next == '0) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop && !push) state_next = ST_PARTIAL;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

`ifdef STICKY_FLAGS_EN
  logic [3:0] sticky_reg;
  logic [3:0] flags_in;

  assign flags_in     = {bus.c_in, bus.z_in, bus.n_in, bus.v_in};
  assign sticky_flags = sticky_reg;

  // Per-flag accumulator; only accepted pushes contribute, and an
  // accumulating push takes precedence over a same-cycle clear.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sticky
      always_ff @(posedge clk) begin
        if (rst) begin
          sticky_reg[gi] <= 1'b0;
        end else if (push) begin
          sticky_reg[gi] <= sticky_reg[gi] | flags_in[gi];
        end else if (clr_sticky) begin
          sticky_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_alu_result_fifo
//   Self-checking bench for alu_result_fifo (N=2, DEPTH=4). A queue-based
//   model predicts head, occupancy and overflow; each scenario task compares
//   DUT outputs against it (and against fixed values where the expected
//   result is known outright).
// -----------------------------------------------------------------------------
module tb_alu_result_fifo;
  localparam int N     = 2;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       clr_ovf;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;
`ifdef STICKY_FLAGS_EN
  logic [3:0] sticky_flags;
  logic       clr_sticky;
`endif

  alu_result_fifo_if #(.N(N)) bus ();

  alu_result_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .clr_ovf      (clr_ovf),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow)
`ifdef STICKY_FLAGS_EN
    ,
    .sticky_flags (sticky_flags),
    .clr_sticky   (clr_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {r,c,z,n,v} entries in push order.
  logic [5:0] q[$];
  logic       ovf_m = 1'b0;
  logic [3:0] sticky_m = 4'b0;

  // Observed / expected status vectors:
  // {out_valid, r_out[1:0], c,z,n,v, full, empty, count[2:0], overflow}
  function automatic logic [12:0] obs_vec();
    return {bus.out_valid, bus.r_out, bus.c_out, bus.z_out, bus.n_out,
            bus.v_out, full, empty, count, overflow};
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [5:0] head;
    logic [2:0] cnt;
    head = (q.size() != 0) ? q[0] : 6'd0;
    cnt  = 3'(q.size());
    return {(q.size() != 0), head, (q.size() == DEPTH), (q.size() == 0),
            cnt, ovf_m};
  endfunction

  task automatic drive(input logic iv, input logic [1:0] r, input logic [3:0] f,
                       input logic ordy, input logic clr, input logic rs);
    bus.in_valid  = iv;
    bus.r_in      = r;
    {bus.c_in, bus.z_in, bus.n_in, bus.v_in} = f;
    bus.out_ready = ordy;
    clr_ovf       = clr;
    rst           = rs;
  endtask

  // Advance one clock and update the model from the inputs applied.
  task automatic tick();
    logic       pop_m, push_m;
    logic [5:0] e;
    pop_m  = (q.size() != 0) && bus.out_ready;
    push_m = bus.in_valid && ((q.size() < DEPTH) || pop_m);
    e      = {bus.r_in, bus.c_in, bus.z_in, bus.n_in, bus.v_in};
    @(posedge clk);
    if (rst) begin
      q.delete();
      ovf_m    = 1'b0;
      sticky_m = 4'b0;
    end else begin
      if (pop_m)  void'(q.pop_front());
      if (push_m) q.push_back(e);
      if (bus.in_valid && !push_m) ovf_m = 1'b1;
      else if (clr_ovf)            ovf_m = 1'b0;
`ifdef STICKY_FLAGS_EN
      if (push_m)          sticky_m = sticky_m | e[3:0];
      else if (clr_sticky) sticky_m = 4'b0;
`endif
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b1, 2'd3, 4'hF, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs_vec() !== 13'b0_00_0000_0_1_000_0) begin
        $display("FAIL reset cycle %0d: got %b want %b", i, obs_vec(),
                 13'b0_00_0000_0_1_000_0);
        errors++;
      end
    end
    drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), (i == 3) ? 4'b1000 : 4'b0000, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL fill push %0d: got %b want %b", i, obs_vec(), exp_vec());
        errors++;
      end
    end
    checks++;
    if (full !== 1'b1 || count !== 3'd4) begin
      $display("FAIL fill full: full=%b count=%0d want full=1 count=4", full, count);
      errors++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.r_out !== 2'(i) || bus.c_out !== (i == 3)) begin
        $display("FAIL drain order %0d: r_out=%0d c_out=%b want r=%0d c=%b",
                 i, bus.r_out, bus.c_out, i, (i == 3));
        errors++;
      end
      tick();
    end
    checks++;
    if (obs_vec() !== exp_vec() || empty !== 1'b1) begin
      $display("FAIL drain empty: got %b want %b", obs_vec(), exp_vec());
      errors++;
    end
    $display("test_fill_drain done");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 4'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 2'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (overflow !== 1'b1 || count !== 3'd4 || obs_vec() !== exp_vec()) begin
      $display("FAIL overflow set: got %b want %b", obs_vec(), exp_vec());
      errors++;
    end
    drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (overflow !== 1'b0 || obs_vec() !== exp_vec()) begin
      $display("FAIL overflow clear: got %b want %b", obs_vec(), exp_vec());
      errors++;
    end
    // Drop and clear in the same cycle: the drop wins.
    drive(1'b1, 2'd2, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (overflow !== 1'b1) begin
      $display("FAIL overflow priority: got %b want 1", overflow);
      errors++;
    end
    $display("test_overflow done");
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 4'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 2'd3, 4'b0001, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (count !== 3'd4 || bus.r_out !== 2'd1 || overflow !== 1'b0) begin
      $display("FAIL full push+pop: count=%0d r_out=%0d ovf=%b want 4 1 0",
               count, bus.r_out, overflow);
      errors++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL full push+pop drain %0d: got %b want %b", i, obs_vec(), exp_vec());
        errors++;
      end
      if (i == 3) begin
        checks++;
        if (bus.r_out !== 2'd3 || bus.v_out !== 1'b1) begin
          $display("FAIL last entry: r_out=%0d v_out=%b want 3 1", bus.r_out, bus.v_out);
          errors++;
        end
      end
      tick();
    end
    $display("test_full_push_pop done");
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    drive(1'b1, 2'd2, 4'd0, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL no fall-through: out_valid=%b want 0", bus.out_valid);
      errors++;
    end
    tick();
    drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || count !== 3'd1 || bus.r_out !== 2'd2) begin
      $display("FAIL empty push: out_valid=%b count=%0d r_out=%0d want 1 1 2",
               bus.out_valid, count, bus.r_out);
      errors++;
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'(i), 4'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (count !== 3'd3) begin
      $display("FAIL count three: got %0d want 3", count);
      errors++;
    end
    drive(1'b1, 2'd1, 4'd0, 1'b1, 1'b0, 1'b1);
    tick();
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || bus.out_valid !== 1'b0 || bus.r_out !== 2'd0) begin
      $display("FAIL mid reset: count=%0d empty=%b out_valid=%b r_out=%0d want 0 1 0 0",
               count, empty, bus.out_valid, bus.r_out);
      errors++;
    end
    drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    $display("test_empty_push_pop done");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 99) == 0));
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL random cycle %0d: got %b want %b", i, obs_vec(), exp_vec());
        errors++;
      end
      tick();
    end
    drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    $display("test_random done");
  endtask

`ifdef STICKY_FLAGS_EN
  task automatic test_sticky();
    clr_sticky = 1'b0;
    do_reset();
    drive(1'b1, 2'd0, 4'b1000, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'd1, 4'b0100, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (sticky_flags !== 4'b1100) begin
      $display("FAIL sticky accumulate: got %b want 1100", sticky_flags);
      errors++;
    end
    drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++;
    if (sticky_flags !== 4'b0000) begin
      $display("FAIL sticky clear: got %b want 0000", sticky_flags);
      errors++;
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'(i), 4'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 2'd3, 4'b0001, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (sticky_flags !== 4'b0000 || overflow !== 1'b1) begin
      $display("FAIL sticky dropped push: sticky=%b ovf=%b want 0000 1",
               sticky_flags, overflow);
      errors++;
    end
    // Random accumulate/clear against the model.
    for (int i = 0; i < 100; i++) begin
      drive(($urandom_range(0, 1) == 1), 2'($urandom), 4'($urandom),
            ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
      clr_sticky = ($urandom_range(0, 4) == 0);
      tick();
      checks++;
      if (sticky_flags !== sticky_m) begin
        $display("FAIL sticky random %0d: got %b want %b", i, sticky_flags, sticky_m);
        errors++;
      end
    end
    clr_sticky = 1'b0;
    drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    $display("test_sticky done");
  endtask
`endif

  initial begin
    drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
`ifdef STICKY_FLAGS_EN
    clr_sticky = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_random();
`ifdef STICKY_FLAGS_EN
    test_sticky();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
